// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants for the iterative multiplier
package mult_pkg;

    localparam int MULT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RSLV = 2'd2,
        DONE = 2'd3
    } state_e;

    // Third-input select for each cell of the shared adder row
    localparam logic ROW_CSA    = 1'b0;
    localparam logic ROW_RIPPLE = 1'b1;

endpackage

// File: rtl/FA.sv
// rtl/FA.sv - single-bit full adder cell
module FA (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/fa_row.sv
// rtl/fa_row.sv - W full adders usable as a carry-save row or a ripple adder
module fa_row
    import mult_pkg::*;
#(
    parameter int W = MULT_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] pp_i,
    input  logic         mode_i,
    output logic [W-1:0] fs_o,
    output logic [W-1:0] fc_o
);

    // Each cell keeps its own carry net so the ripple chain links scalars, not bits of one vector
    for (genvar j = 0; j < W; j++) begin : g_cell
        logic ci;
        logic co;
        logic so;

        if (j == 0) begin : g_first
            assign ci = (mode_i == ROW_RIPPLE) ? 1'b0 : pp_i[j];
        end else begin : g_rest
            assign ci = (mode_i == ROW_RIPPLE) ? g_cell[j-1].co : pp_i[j];
        end

        FA u_fa (
            .a_i (a_i[j]),
            .b_i (b_i[j]),
            .c_i (ci),
            .s_o (so),
            .c_o (co)
        );

        assign fs_o[j] = so;
        assign fc_o[j] = co;
    end

endmodule

// File: rtl/csa_mult_ctrl.sv
// rtl/csa_mult_ctrl.sv - sequences one fa_row over W carry-save steps plus one ripple resolve
module csa_mult_ctrl
    import mult_pkg::*;
#(
    parameter int W = MULT_W
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*W-1:0] p_o
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_e           state_q;
    logic [W-1:0]     areg_q;
    logic [W-1:0]     breg_q;
    logic [W-1:0]     sreg_q;
    logic [W-1:0]     creg_q;
    logic [W-1:0]     lo_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [2*W-1:0]   p_q;

    logic [W-1:0]     pp;
    logic [W-1:0]     fs;
    logic [W-1:0]     fc;
    logic             row_mode;

    assign pp       = areg_q & {W{breg_q[0]}};
    assign row_mode = (state_q == RSLV) ? ROW_RIPPLE : ROW_CSA;

    fa_row #(.W(W)) u_row (
        .a_i    (sreg_q),
        .b_i    (creg_q),
        .pp_i   (pp),
        .mode_i (row_mode),
        .fs_o   (fs),
        .fc_o   (fc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            areg_q  <= '0;
            breg_q  <= '0;
            sreg_q  <= '0;
            creg_q  <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        areg_q  <= a_i;
                        breg_q  <= b_i;
                        sreg_q  <= '0;
                        creg_q  <= '0;
                        lo_q    <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ACC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACC: begin
                    // Bit 0 of the running sum is final; it retires into the low half
                    lo_q   <= {fs[0], lo_q[W-1:1]};
                    sreg_q <= {1'b0, fs[W-1:1]};
                    creg_q <= fc;
                    breg_q <= breg_q >> 1;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= RSLV;
                    end
                end
                RSLV: begin
                    p_q     <= {fs, lo_q};
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign p_o    = p_q;

endmodule
